// File: rtl/as2650_pkg.sv
// Shared definitions for the AS2650 system-bus controller: bus FSM states,
// address-space encoding and wait-state limits.
package as2650_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_t;

  localparam logic        SPACE_MEM = 1'b1;
  localparam logic        SPACE_IO  = 1'b0;
  localparam int unsigned MAX_WAIT  = 15;
  localparam int          CNT_W     = 4;

  // Out-of-range wait parameters saturate rather than wrap.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned w);
    return (w > MAX_WAIT) ? CNT_W'(MAX_WAIT) : CNT_W'(w);
  endfunction

endpackage

// File: rtl/as2650_irq_prio.sv
// Interrupt capture and acknowledge for the AS2650 bus controller: per-channel
// synchronisers, rising-edge pending latches, lowest-index priority and vector.
module as2650_irq_prio
  import as2650_pkg::*;
#(
  parameter int unsigned N_IRQ    = 4,
  parameter logic [7:0]  VEC_BASE = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             inta,
  output logic             intr,
  output logic [7:0]       vec,
  output logic             vec_oe
);

  logic [N_IRQ-1:0] sync1, sync2, sync3;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic             inta_q;
  logic             inta_rise;
  logic [2:0]       k;

  assign rise      = sync2 & ~sync3;
  assign inta_rise = inta & ~inta_q;
  assign intr      = |pending;

  always_comb begin
    k = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) k = 3'(i);
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = inta_rise & pending[i] & (k == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      pending <= '0;
      inta_q  <= 1'b0;
      vec     <= 8'h00;
      vec_oe  <= 1'b0;
    end else begin
      sync1   <= irq;
      sync2   <= sync1;
      sync3   <= sync2;
      // A fresh edge outranks an acknowledge clearing the same channel.
      pending <= (pending & ~clr) | rise;
      inta_q  <= inta;
      vec_oe  <= inta;
      if (inta_rise) vec <= VEC_BASE + 8'({k, 1'b0});
    end
  end

endmodule

// File: rtl/as2650_sysbus.sv
// AS2650 system-bus controller: opack generation with per-space wait states and
// ext_rdy stretch; interrupt logic present only when AS2650_SYSBUS_IRQ_EN is defined.
//
// state | meaning
// IDLE  | no request in progress, selects low
// WAIT  | request latched, counting wait states while ext_rdy=1
// ACK   | wait done, opack asserted until opreq drops
module as2650_sysbus
  import as2650_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned N_IRQ    = 4,
  parameter logic [7:0]  VEC_BASE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              opreq,
  input  logic              m_io,
  input  logic              rw,
  input  logic [ADDR_W-1:0] adr,
  input  logic              ext_rdy,
  output logic              opack,
  output logic              mem_cs,
  output logic              io_cs,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_adr,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              inta,
  output logic              intr,
  output logic [7:0]        vec,
  output logic              vec_oe
);

  localparam logic [CNT_W-1:0] MEM_W = wait_load(MEM_WAIT);
  localparam logic [CNT_W-1:0] IO_W  = wait_load(IO_WAIT);

  bus_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] w_sel;
  logic             accept;
  logic             opack_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    opack_nx = 1'b0;
    w_sel    = (m_io == SPACE_MEM) ? MEM_W : IO_W;
    case (state)
      IDLE: begin
        if (opreq) begin
          accept   = 1'b1;
          cnt_nx   = w_sel;
          state_nx = (w_sel == '0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!opreq) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (ext_rdy) begin
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = ACK;
        end
      end
      ACK: begin
        if (!opreq) state_nx = IDLE;
        else        opack_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      opack   <= 1'b0;
      mem_cs  <= 1'b0;
      io_cs   <= 1'b0;
      bus_we  <= 1'b0;
      bus_adr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      opack <= opack_nx;
      if (accept) begin
        mem_cs  <= (m_io == SPACE_MEM);
        io_cs   <= (m_io == SPACE_IO);
        bus_we  <= rw;
        bus_adr <= adr;
      end else if (state_nx == IDLE) begin
        mem_cs <= 1'b0;
        io_cs  <= 1'b0;
      end
    end
  end

`ifdef AS2650_SYSBUS_IRQ_EN
  as2650_irq_prio #(
    .N_IRQ    (N_IRQ),
    .VEC_BASE (VEC_BASE)
  ) u_irq_prio (
    .clk    (clk),
    .reset  (reset),
    .irq    (irq),
    .inta   (inta),
    .intr   (intr),
    .vec    (vec),
    .vec_oe (vec_oe)
  );
`else
  logic unused_irq;
  assign unused_irq = ^{irq, inta};
  assign intr       = 1'b0;
  assign vec        = 8'h00;
  assign vec_oe     = 1'b0;
`endif

endmodule

// File: tb/tb_as2650_sysbus.sv
// Self-checking bench for as2650_sysbus: directed scenarios plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_as2650_sysbus;

  localparam int         ADDR_W   = 13;
  localparam int         MEM_WAIT = 0;
  localparam int         IO_WAIT  = 2;
  localparam int         N_IRQ    = 4;
  localparam logic [7:0] VEC_BASE = 8'h10;

  logic              clk = 1'b0;
  logic              reset;
  logic              opreq, m_io, rw, ext_rdy, inta;
  logic [ADDR_W-1:0] adr;
  logic [N_IRQ-1:0]  irq;
  logic              opack, mem_cs, io_cs, bus_we, intr, vec_oe;
  logic [ADDR_W-1:0] bus_adr;
  logic [7:0]        vec;

  int n_cmp = 0;
  int n_bad = 0;

  as2650_sysbus #(
    .ADDR_W(ADDR_W), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT),
    .N_IRQ(N_IRQ), .VEC_BASE(VEC_BASE)
  ) dut (
    .clk(clk), .reset(reset), .opreq(opreq), .m_io(m_io), .rw(rw), .adr(adr),
    .ext_rdy(ext_rdy), .opack(opack), .mem_cs(mem_cs), .io_cs(io_cs),
    .bus_we(bus_we), .bus_adr(bus_adr), .irq(irq), .inta(inta), .intr(intr),
    .vec(vec), .vec_oe(vec_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request is "busy" from acceptance until opreq drops;
  // it acknowledges once it has seen as many ready edges as its wait count.
  logic              m_busy = 0, m_space = 0, m_we = 0, m_opack = 0;
  logic [ADDR_W-1:0] m_adr = '0;
  int                m_need = 0, m_got = 0;
  logic [N_IRQ-1:0]  m_pend = '0;
  logic [7:0]        m_vec = 8'h00;
  logic              m_vec_oe = 0, m_inta_prev = 0;
  logic [N_IRQ-1:0]  hist[$] = '{'0, '0, '0};
  logic [N_IRQ-1:0]  m_rise;
  int                m_k;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_space = 0; m_we = 0; m_opack = 0; m_adr = '0;
      m_need = 0; m_got = 0;
      m_pend = '0; m_vec = 8'h00; m_vec_oe = 0; m_inta_prev = 0;
      hist = '{'0, '0, '0};
    end else begin
      if (!m_busy) begin
        m_opack = 0;
        if (opreq) begin
          m_busy = 1; m_space = m_io; m_we = rw; m_adr = adr;
          m_need = m_io ? MEM_WAIT : IO_WAIT; m_got = 0;
        end
      end else if (!opreq) begin
        m_busy = 0; m_opack = 0;
      end else if (m_got >= m_need) begin
        m_opack = 1;
      end else if (ext_rdy) begin
        m_got++;
      end
`ifdef AS2650_SYSBUS_IRQ_EN
      // Source level sampled two edges ago rose relative to three edges ago.
      m_rise = hist[1] & ~hist[2];
      if (inta && !m_inta_prev) begin
        m_k = 0;
        for (int i = N_IRQ - 1; i >= 0; i--) if (m_pend[i]) m_k = i;
        m_pend[m_k] = 1'b0;
        m_vec = 8'(int'(VEC_BASE) + 2 * m_k);
      end
      m_pend = m_pend | m_rise;
      m_vec_oe = inta;
      m_inta_prev = inta;
      hist.push_front(irq);
      void'(hist.pop_back());
`endif
    end
  end

  always @(negedge clk) begin
    chk("opack", opack, m_opack);
    chk("mem_cs", mem_cs, m_busy && m_space);
    chk("io_cs", io_cs, m_busy && !m_space);
    chk("bus_we", bus_we, m_we);
    chk("bus_adr", bus_adr, m_adr);
    chk("intr", intr, |m_pend);
    chk("vec", vec, m_vec);
    chk("vec_oe", vec_oe, m_vec_oe);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    bit io_ok;
    int idx;
    reset = 1; opreq = 0; m_io = 0; rw = 0; adr = '0; ext_rdy = 1; inta = 0; irq = '0;
    repeat (3) tick();
    chk("rst_opack", opack, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_bus_adr", bus_adr, 0);
    chk("rst_vec", vec, 0);
    chk("rst_intr", intr, 0);
    reset = 0;
    tick();

    // Zero-wait memory access
    opreq = 1; m_io = 1; rw = 0; adr = 13'h0123;
    tick();
    chk("zw_mem_cs", mem_cs, 1);
    chk("zw_bus_adr", bus_adr, 13'h0123);
    chk("zw_opack_early", opack, 0);
    tick();
    chk("zw_opack", opack, 1);
    opreq = 0; adr = '0;
    tick();
    chk("zw_release", opack, 0);
    chk("zw_mem_cs_clr", mem_cs, 0);

    // I/O with two waits and three stalled cycles
    opreq = 1; m_io = 0; rw = 1; adr = 13'h1abc;
    tick();
    n = 0; io_ok = 1;
    for (int e = 1; e <= 20; e++) begin
      ext_rdy = (e >= 2 && e <= 4) ? 1'b0 : 1'b1;
      tick();
      if (!io_cs) io_ok = 0;
      if (opack) begin n = e; break; end
    end
    chk("io_ack_edge", n, 6);
    chk("io_cs_held", io_ok, 1);
    chk("io_we", bus_we, 1);
    opreq = 0; ext_rdy = 1;
    tick();
    chk("io_release", opack, 0);

    // Abort during wait states
    opreq = 1; m_io = 0;
    tick();
    chk("ab_io_cs", io_cs, 1);
    opreq = 0;
    tick();
    chk("ab_io_cs_clr", io_cs, 0);
    repeat (3) begin
      tick();
      chk("ab_opack", opack, 0);
    end

`ifdef AS2650_SYSBUS_IRQ_EN
    irq = 4'b1010;
    tick(); tick();
    chk("irq_lat_early", intr, 0);
    tick();
    chk("irq_lat", intr, 1);
    inta = 1; tick();
    chk("pri_vec1", vec, 8'h12);
    chk("pri_vec_oe", vec_oe, 1);
    chk("pri_intr1", intr, 1);
    inta = 0; tick();
    chk("pri_vec_oe_off", vec_oe, 0);
    inta = 1; tick();
    chk("pri_vec2", vec, 8'h16);
    chk("pri_intr2", intr, 0);
    inta = 0; irq = '0;
    repeat (4) tick();

    // New edge on channel 0 coinciding with its acknowledge
    irq[0] = 1; repeat (3) tick();
    irq[0] = 0; repeat (3) tick();
    irq[0] = 1; tick(); tick();
    inta = 1; tick();
    chk("sc_vec", vec, 8'h10);
    chk("sc_still_pend", intr, 1);
    inta = 0; tick();
    inta = 1; tick();
    chk("sc_vec2", vec, 8'h10);
    chk("sc_cleared", intr, 0);
    inta = 0; irq = '0; tick();

    // Acknowledge with nothing pending
    repeat (3) tick();
    inta = 1; tick();
    chk("np_vec", vec, VEC_BASE);
    chk("np_vec_oe", vec_oe, 1);
    chk("np_intr", intr, 0);
    inta = 0; tick();
`else
    for (int t = 0; t < 12; t++) begin
      irq = 4'(t * 5);
      inta = t[0];
      tick();
      chk("noirq_intr", intr, 0);
      chk("noirq_vec_oe", vec_oe, 0);
    end
    irq = '0; inta = 0;
    repeat (4) tick();
`endif

    // Reset while acknowledging with two interrupts pending
    irq = 4'b0110;
    repeat (3) tick();
    opreq = 1; m_io = 1; adr = 13'h0777;
    tick(); tick();
    chk("rs_opack_pre", opack, 1);
`ifdef AS2650_SYSBUS_IRQ_EN
    chk("rs_intr_pre", intr, 1);
`endif
    #1 reset = 1;
    #1;
    chk("rs_opack", opack, 0);
    chk("rs_mem_cs", mem_cs, 0);
    chk("rs_bus_adr", bus_adr, 0);
    chk("rs_intr", intr, 0);
    chk("rs_vec_oe", vec_oe, 0);
    opreq = 0; irq = '0;
    tick();
    reset = 0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!opreq) begin
        if ($urandom_range(0, 2) == 0) opreq = 1;
      end else if ($urandom_range(0, opack ? 1 : 9) == 0) begin
        opreq = 0;
      end
      m_io    = 1'($urandom_range(0, 1));
      rw      = 1'($urandom_range(0, 1));
      adr     = ADDR_W'($urandom);
      ext_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, N_IRQ - 1);
        irq[idx] = ~irq[idx];
      end
      if (inta) inta = ($urandom_range(0, 1) == 0);
      else      inta = ($urandom_range(0, 6) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/as2650_sysbus.md
# as2650_sysbus

Parametrised system-bus controller for the AS2650 core. It sits between the CPU's operation-request bus and external memory and I/O, and generates `opack` with configurable wait states per space plus an external-ready stretch. It also aggregates N edge-triggered interrupt lines into the CPU's `intr` and supplies a prioritised vector during interrupt acknowledge. It replaces the hard-wired `opack=1`, `intr=0` tie-offs of the first-generation harness.

## Interface
Parameters:
- `ADDR_W`, 13: CPU address width (15 for extended-address builds).
- `MEM_WAIT`, 0: wait states for memory operations (0–15).
- `IO_WAIT`, 2: wait states for I/O operations (0–15).
- `N_IRQ`, 4: interrupt channels (1–8).
- `VEC_BASE`, 8'h00: vector for channel 0.

Ports:
- `clk`  in  1  system clock, all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opreq`  in  1  CPU operation request.
- `m_io`  in  1  1 = memory, 0 = I/O.
- `rw`  in  1  1 = write.
- `adr`  in  ADDR_W  CPU address; passed through as `bus_adr`.
- `ext_rdy`  in  1  external ready; 0 freezes the wait counter.
- `opack`  out  1  operation acknowledge to the CPU.
- `mem_cs` / `io_cs`  out  1  registered space selects.
- `bus_we`  out  1  `rw` latched at request start.
- `bus_adr`  out  ADDR_W  `adr` latched at request start.
- `irq`  in  N_IRQ  asynchronous interrupt sources, rising-edge sensitive.
- `inta`  in  1  interrupt-acknowledge strobe from the CPU.
- `intr`  out  1  interrupt request to the CPU.
- `vec`  out  8  interrupt vector, valid while `vec_oe` is high.
- `vec_oe`  out  1  vector drive enable.

## Operation
- Bus FSM states: IDLE, WAIT, ACK.
  - **IDLE:** when `opreq`=1 is sampled, latch `m_io`, `rw` and `adr`. Assert `mem_cs`/`io_cs` and load the counter with W (`MEM_WAIT` or `IO_WAIT`). Go to ACK if W=0, otherwise go to WAIT.
  - **WAIT:** the counter decrements only on edges where `ext_rdy`=1. Go to ACK when the counter reaches 0.
  - **ACK:** `opack`=1. When `opreq`=0 is sampled, go to IDLE and clear `opack`, `mem_cs` and `io_cs`.
- **Abort:** `opreq`=0 sampled in WAIT returns the FSM to IDLE and clears the selects. `opack` is never asserted for that request.
- `opreq` must drop before a new request is accepted; there is no back-to-back acceptance from ACK.
- **Interrupt capture:**
  - `irq` passes through a 2-flop synchroniser per channel.
  - A rising edge on the synchronised signal sets `pending[i]`.
  - `intr` = |`pending`.
- **Interrupt acknowledge:**
  - On a rising edge of `inta`, select the lowest-index pending channel k and clear `pending[k]`.
  - Register `vec` = `VEC_BASE` + 2·k, with 8-bit wrap.
  - Hold `vec_oe`=1 while `inta` stays high.
- **Simultaneous set and clear** on the same channel in the same cycle: set wins, and the channel stays pending.
- **`inta` with nothing pending:** `vec` = `VEC_BASE`, `vec_oe`=1, no state change.

## Timing
- **Reset values:** FSM in IDLE, counter 0, all `pending` clear, synchronisers 0. `opack`, `mem_cs`, `io_cs`, `bus_we`, `intr` and `vec_oe` are 0; `vec` = 8'h00; `bus_adr` = 0.
- **Reset mid-operation:** all outputs drop asynchronously. The CPU must re-issue the request.
- **Acknowledge latency:** `opreq` sampled at edge E0 gives `opack`=1 after edge E0+W+1, with `ext_rdy` held high. Each low cycle of `ext_rdy` adds 1 cycle.
- **Release:** `opack` falls 1 edge after `opreq`=0 is sampled.
- **Interrupt latency:** an `irq` edge raises `intr` 3 edges later (2 synchroniser edges + 1 pending edge).
- **Vector timing:** `vec`/`vec_oe` are valid 1 edge after `inta` rises. `intr` falls on the same edge if no other channel is pending.

## Configuration
Macro `AS2650_SYSBUS_IRQ_EN`:
- **Defined:** the interrupt logic is present as described above.
- **Undefined:** `intr`, `vec_oe` and `vec` are constant 0, `irq` and `inta` are ignored, and no interrupt flops are synthesised. Bus behaviour is identical in both builds.

## Structure
- **Shared package `as2650_pkg`:** FSM state enum (IDLE/WAIT/ACK), the space encoding constants `SPACE_MEM`=1 and `SPACE_IO`=0, and the maximum wait-state constant 15.
- **Sub-module:** one, `as2650_irq_prio`. It contains the synchronisers, pending register, priority encoder and vector register, and is instantiated only under `AS2650_SYSBUS_IRQ_EN`.

## Test plan
- **Zero-wait memory:** `MEM_WAIT`=0, `opreq`=1 with `m_io`=1 and `adr`=13'h0123 → `mem_cs`=1, `bus_adr`=13'h0123 and `opack`=1 one edge later. `opack`=0 one edge after `opreq` drops.
- **I/O wait with stretch:** `IO_WAIT`=2, `ext_rdy` low for 3 cycles mid-wait → `opack` at E0+6. `io_cs`=1 throughout.
- **Abort:** `opreq` drops in WAIT → FSM returns to IDLE, `opack` stays 0, selects clear.
- **Interrupt priority:** edges on `irq[3]` and `irq[1]`, then two `inta` pulses with `VEC_BASE`=8'h10 → vectors 8'h12 then 8'h16. `intr` falls after the second pulse.
- **Boundary cases:**
  - `irq[0]` edge on the same cycle as `inta` clears channel 0 → channel 0 stays pending.
  - `inta` with nothing pending → `vec`=`VEC_BASE`.
- **Reset:** assert `reset` during ACK and with 2 interrupts pending → all outputs 0 immediately. Macro-undefined build: `irq` toggling → `intr` stays 0.
